// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: state encoding and round-robin search shared by the latch bank write controller.
package latch_ctrl_pkg;
   localparam int ST_W    = 3;
   localparam int MAX_REQ = 32;
   localparam int RR_IW   = $clog2(MAX_REQ);
   typedef enum logic [ST_W-1:0] {IDLE, SETUP, OPEN, HOLD, CLR} lat_wr_state_e;
   // First valid index after ptr, wrapping modulo n; -1 when nothing is valid.
   function automatic int rr_next(input int n, input int ptr, input logic [MAX_REQ-1:0] valid);
      logic [RR_IW-1:0] k;
      rr_next = -1;
      for (int i = n; i >= 1; i--) begin
         k = RR_IW'((ptr + i) % n);
         if (valid[k]) rr_next = int'(k);
      end
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant over N requesters; owns the last-granted pointer.
module rr_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] valid_i,
   input  logic         advance_i,
   output logic [N-1:0] grant_o
);
   logic [PW-1:0] ptr_q, ptr_d;
   int idx;
   always_comb begin
      idx = rr_next(N, int'(ptr_q), MAX_REQ'(valid_i));
      grant_o = '0;
      if (idx >= 0) grant_o[PW'(idx)] = 1'b1;
      ptr_d = (advance_i && idx >= 0) ? PW'(idx) : ptr_q;
   end
   // Reset to the last index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr_q <= PW'(N - 1);
      else ptr_q <= ptr_d;
endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// latch_bank_wr_ctrl: round-robin write sequencer driving a latch bank in setup/open(/hold) order.
// Define LATCH_WR_CTRL_HOLD_EN to insert a HOLD cycle after each enable window.
module latch_bank_wr_ctrl
   import latch_ctrl_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int NUM_ENTRIES = 8,
   parameter  int DATA_W      = 4,
   localparam int AW          = $clog2(NUM_ENTRIES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*AW-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      clr_req,
   output logic                      clr_done,
   output logic [NUM_ENTRIES-1:0]    lat_en,
   output logic [DATA_W-1:0]         lat_d,
   output logic                      lat_clr,
   output logic                      busy,
   output logic                      err_addr
);
`ifdef LATCH_WR_CTRL_HOLD_EN
   localparam lat_wr_state_e OPEN_NXT = HOLD;
`else
   localparam lat_wr_state_e OPEN_NXT = IDLE;
`endif
   lat_wr_state_e state_q, state_d;
   logic init_q;
   logic [AW-1:0] addr_q, addr_d, sel_addr;
   logic [DATA_W-1:0] lat_d_q, lat_d_d, sel_data;
   logic [NUM_ENTRIES-1:0] lat_en_q, lat_en_d;
   logic lat_clr_q, lat_clr_d, clr_done_q, clr_done_d, busy_q, busy_d, err_q, err_d;
   logic [NUM_REQ-1:0] grant;
   logic can_acc, accept, addr_ok;
   // Writes wait while the bank is clearing; a pending clear beats any write.
   assign can_acc   = state_q == IDLE && !lat_clr_q && !clr_req;
   assign req_ready = grant & {NUM_REQ{can_acc}};
   assign accept    = |req_ready;
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (req_valid),
      .advance_i (accept),
      .grant_o   (grant)
   );
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_ready[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         init_q     <= 1'b1;
         addr_q     <= '0;
         lat_d_q    <= '0;
         lat_en_q   <= '0;
         lat_clr_q  <= 1'b1;
         clr_done_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_q     <= 1'b0;
         addr_q     <= addr_d;
         lat_d_q    <= lat_d_d;
         lat_en_q   <= lat_en_d;
         lat_clr_q  <= lat_clr_d;
         clr_done_q <= clr_done_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = lat_clr_q ? IDLE : clr_req ? CLR : accept ? SETUP : IDLE;
         SETUP:   state_d = OPEN;
         OPEN:    state_d = OPEN_NXT;
         default: state_d = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      addr_ok    = int'(addr_q) < NUM_ENTRIES;
      addr_d     = accept ? sel_addr : addr_q;
      lat_d_d    = accept ? sel_data : lat_d_q;
      lat_en_d   = (state_d == OPEN && addr_ok) ? NUM_ENTRIES'(1) << addr_q : '0;
      err_d      = state_d == OPEN && !addr_ok;
      lat_clr_d  = init_q || state_d == CLR;
      clr_done_d = state_q == CLR;
      busy_d     = state_d != IDLE;
   end
   assign lat_en   = lat_en_q;
   assign lat_d    = lat_d_q;
   assign lat_clr  = lat_clr_q;
   assign clr_done = clr_done_q;
   assign busy     = busy_q;
   assign err_addr = err_q;
endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// tb_latch_bank_wr_ctrl: directed and randomized check of latch_bank_wr_ctrl against a
// transaction timeline model (each acceptance schedules its expected outputs by cycle).
module tb_latch_bank_wr_ctrl;
   localparam int NR = 4, NE = 6, DW = 4, AW = 3, MAXC = 2048;
`ifdef LATCH_WR_CTRL_HOLD_EN
   localparam int WR_LEN = 4;
`else
   localparam int WR_LEN = 3;
`endif
   logic clk = 1'b0;
   logic rst_n;
   logic [NR-1:0] req_valid, req_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic clr_req, clr_done, lat_clr, busy, err_addr;
   logic [NE-1:0] lat_en;
   logic [DW-1:0] lat_d;

   latch_bank_wr_ctrl #(.NUM_REQ(NR), .NUM_ENTRIES(NE), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .clr_req(clr_req), .clr_done(clr_done),
      .lat_en(lat_en), .lat_d(lat_d), .lat_clr(lat_clr), .busy(busy), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   bit v[NR];
   int adr[NR], dat[NR];
   bit clr, keep, rnd;
   int x_en[MAXC], d_val[MAXC];
   bit x_err[MAXC], x_clr[MAXC], x_done[MAXC], x_busy[MAXC], d_chg[MAXC];
   int c, cur_d, last, next_free, exp_rdy;
   int n_cmp, n_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, obs, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = v[i];
         req_addr[i*AW +: AW] = AW'(adr[i]);
         req_data[i*DW +: DW] = DW'(dat[i]);
      end
      clr_req = clr;
   endtask

   task automatic model_check();
      int w;
      if (d_chg[c]) cur_d = d_val[c];
      chk("lat_en", 32'(lat_en), x_en[c]);
      chk("lat_d", 32'(lat_d), cur_d);
      chk("lat_clr", 32'(lat_clr), 32'(x_clr[c]));
      chk("clr_done", 32'(clr_done), 32'(x_done[c]));
      chk("busy", 32'(busy), 32'(x_busy[c]));
      chk("err_addr", 32'(err_addr), 32'(x_err[c]));
      exp_rdy = 0;
      if (c >= next_free) begin
         if (clr) begin
            x_clr[c+1] = 1; x_busy[c+1] = 1; x_done[c+2] = 1;
            next_free = c + 2;
         end else begin
            w = -1;
            for (int k = 1; k <= NR && w < 0; k++)
               if (v[(last + k) % NR]) w = (last + k) % NR;
            if (w >= 0) begin
               exp_rdy = 1 << w;
               last = w;
               d_chg[c+1] = 1; d_val[c+1] = dat[w];
               if (adr[w] < NE) x_en[c+2] = 1 << adr[w];
               else x_err[c+2] = 1;
               for (int k = 1; k < WR_LEN; k++) x_busy[c+k] = 1;
               next_free = c + WR_LEN;
            end
         end
      end
      chk("req_ready", 32'(req_ready), exp_rdy);
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      c++;
      if (c >= MAXC - 8) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", c, MAXC - 8);
         $fatal(1);
      end
      for (int i = 0; i < NR; i++)
         if (exp_rdy[i]) begin
            v[i] = keep;
            adr[i] = $urandom_range(0, NE - 1);
            dat[i] = $urandom_range(0, 15);
         end
      clr = 0;
      if (rnd) begin
         for (int i = 0; i < NR; i++)
            if (!v[i] && $urandom_range(0, 99) < 40) begin
               v[i] = 1;
               adr[i] = $urandom_range(0, 7);
               dat[i] = $urandom_range(0, 15);
            end
         clr = $urandom_range(0, 99) < 8;
      end
      apply();
   endtask

   task automatic do_reset();
      rst_n = 0;
      for (int i = 0; i < NR; i++) begin v[i] = 0; adr[i] = 0; dat[i] = 0; end
      clr = 0; keep = 0; rnd = 0;
      apply();
      for (int i = 0; i < MAXC; i++) begin
         x_en[i] = 0; d_val[i] = 0; x_err[i] = 0; x_clr[i] = 0;
         x_done[i] = 0; x_busy[i] = 0; d_chg[i] = 0;
      end
      c = 0; cur_d = 0; last = NR - 1; next_free = 2; exp_rdy = 0;
      x_clr[0] = 1; x_clr[1] = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lat_clr", 32'(lat_clr), 1);
      chk("rst_lat_en", 32'(lat_en), 0);
      chk("rst_lat_d", 32'(lat_d), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_clr_done", 32'(clr_done), 0);
      chk("rst_err_addr", 32'(err_addr), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      rst_n = 1;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1;
      #2;
      do_reset();
      repeat (3) step();
      v[2] = 1; adr[2] = 5; dat[2] = 'hA; apply();
      repeat (6) step();
      keep = 1;
      for (int i = 0; i < NR; i++) begin v[i] = 1; adr[i] = $urandom_range(0, NE - 1); dat[i] = $urandom_range(0, 15); end
      apply();
      repeat (4 * WR_LEN + 2) step();
      keep = 0;
      repeat (4 * WR_LEN + 2) step();
      clr = 1; v[1] = 1; adr[1] = 3; dat[1] = 7; apply();
      repeat (8) step();
      v[0] = 1; adr[0] = 7; dat[0] = 3; apply();
      repeat (5) step();
      v[3] = 1; adr[3] = 6; dat[3] = 12; apply();
      repeat (5) step();
      rnd = 1;
      repeat (300) step();
      rnd = 0;
      for (int i = 0; i < NR; i++) v[i] = 0;
      clr = 0; apply();
      repeat (6) step();
      v[3] = 1; adr[3] = 2; dat[3] = 9; apply();
      repeat (2) step();
      chk("open_lat_en", 32'(lat_en), 32'h4);
      #2;
      rst_n = 0;
      #1;
      chk("arst_lat_en", 32'(lat_en), 0);
      chk("arst_lat_clr", 32'(lat_clr), 1);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_lat_d", 32'(lat_d), 0);
      chk("arst_req_ready", 32'(req_ready), 0);
      do_reset();
      keep = 1;
      for (int i = 0; i < NR; i++) begin v[i] = 1; adr[i] = $urandom_range(0, NE - 1); dat[i] = $urandom_range(0, 15); end
      apply();
      repeat (2 * WR_LEN + 4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
